// File: rtl/spi_frame_responder.sv
// SPI peripheral frame link for the FFT core: deserialises one frame from
// sdi, hands it off, then streams the core's result back out on sdo.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   sck, sdi, sdo     SPI pins (sck oversampled in the clk domain)
//   rx_frame/rx_valid last complete input frame and its 1-clk update pulse
//   result/_valid     FFT core output frame and its load strobe
//   done, busy, err   result loaded / waiting for result / sck edge while busy
module spi_frame_responder #(
   parameter int FRAME_BITS = 1024,
   parameter int CNT_W      = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  sdi,
   output logic                  sdo,
   output logic [FRAME_BITS-1:0] rx_frame,
   output logic                  rx_valid,
   input  logic [FRAME_BITS-1:0] result,
   input  logic                  result_valid,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   localparam logic [0:0] S_RECV = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

   logic                  sck_s1_q, sck_s2_q, sck_s3_q;
   logic                  sdi_s1_q, sdi_s2_q;
   logic                  rise, fall;

   logic [0:0]            state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [FRAME_BITS-1:0] rx_frame_q, rx_frame_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   // sdi runs through the same two-stage delay as sck so that sdi_s2_q
   // is the bit that was on the pin when the detected rise happened.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_s3_q <= 1'b0;
         sdi_s1_q <= 1'b0;
         sdi_s2_q <= 1'b0;
      end else begin
         sck_s1_q <= sck;
         sck_s2_q <= sck_s1_q;
         sck_s3_q <= sck_s2_q;
         sdi_s1_q <= sdi;
         sdi_s2_q <= sdi_s1_q;
      end
   end

   assign rise = sck_s2_q & ~sck_s3_q;
   assign fall = ~sck_s2_q & sck_s3_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      rx_frame_d = rx_frame_q;
      rx_valid_d = 1'b0;
      done_d     = done_q;
      err_d      = err_q;
      unique case (state_q)
         S_RECV: begin
            // result_valid is deliberately ignored here, which also makes
            // a last-bit rise win over a coincident strobe.
            if (rise) begin
               rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], sdi_s2_q};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == '0) begin
                  done_d = 1'b0;
               end
               if (bit_cnt_q == LAST) begin
                  rx_frame_d = {rx_shift_q[FRAME_BITS-2:0], sdi_s2_q};
                  bit_cnt_d  = '0;
                  rx_valid_d = 1'b1;
                  state_d    = S_BUSY;
               end
            end else if (fall) begin
               tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
            end
         end
         S_BUSY: begin
            if (rise) begin
               err_d = 1'b1;
            end
            if (result_valid) begin
               tx_shift_d = result;
               done_d     = 1'b1;
               state_d    = S_RECV;
            end
         end
         default: begin
            state_d = S_RECV;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RECV;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         rx_frame_q <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         rx_frame_q <= rx_frame_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // MSB of the shifter drives the pin directly, so a freshly loaded
   // result is visible before the first rise of the next frame.
   assign sdo      = tx_shift_q[FRAME_BITS-1];
   assign rx_frame = rx_frame_q;
   assign rx_valid = rx_valid_q;
   assign done     = done_q;
   assign busy     = (state_q == S_BUSY);
   assign err      = err_q;

endmodule
